// File: rtl/dlsc_pcie_s6_pkg.sv
// Shared definitions for the Spartan-6 PCIe transmit path.
//   - TLP_W      : width of one TLP beat on the core tx interface.
//   - arb_state_e: arbiter state encoding (IDLE=0, CPL=1, REQ=2).
//   - sat_inc16  : saturating 16-bit increment used by statistics counters.
package dlsc_pcie_s6_pkg;

  localparam int TLP_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPL  = 2'd1,
    ST_REQ  = 2'd2
  } arb_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

endpackage

// File: rtl/dlsc_pcie_s6_tx_arbiter_outreg.sv
// Single registered output stage for a valid/ready beat stream.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_ready            : load enable; the upstream beat is taken when in_valid & in_ready
//   in_valid/data/last  : upstream beat
//   out_ready           : downstream accept
//   out_valid/data/last : registered downstream beat, held stable until out_ready
module dlsc_pcie_s6_tx_arbiter_outreg
  import dlsc_pcie_s6_pkg::*;
#(
  parameter int W = TLP_W
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         in_ready,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q,  data_d;
  logic         last_q,  last_d;
  logic         load_en_s;

  // The register may be reloaded when it is empty or its beat leaves this cycle.
  assign load_en_s = ~valid_q | out_ready;

  // Next-value logic: load a new beat (or go empty) on load enable, else hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load_en_s) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
        last_d = in_last;
      end else begin
        data_d = data_q;
        last_d = last_q;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign in_ready  = load_en_s;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;

endmodule

// File: rtl/dlsc_pcie_s6_tx_arbiter.sv
// Packet-locked arbiter sharing the Spartan-6 PCIe tx port between the
// inbound completion stream (CPL, fixed priority) and the outbound request
// stream (REQ), with an anti-starvation limit for REQ and tx buffer gating.
// Optional statistics: define DLSC_PCIE_S6_TX_ARBITER_STATS_EN.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   cpl_ready/valid/data/last       : CPL source beat stream
//   req_ready/valid/data/last       : REQ source beat stream
//   tx_buf_av                       : core transmit buffers available
//   tx_ready / tx_valid/data/last   : registered core tx interface
//   gnt_cpl / gnt_req               : registered grant status
//   stat_clr, stat_cpl_pkts, stat_req_pkts, stat_starve : statistics (macro only)
module dlsc_pcie_s6_tx_arbiter
  import dlsc_pcie_s6_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned BUF_MIN      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             cpl_ready,
  input  logic             cpl_valid,
  input  logic [TLP_W-1:0] cpl_data,
  input  logic             cpl_last,
  output logic             req_ready,
  input  logic             req_valid,
  input  logic [TLP_W-1:0] req_data,
  input  logic             req_last,
  input  logic [5:0]       tx_buf_av,
  input  logic             tx_ready,
  output logic             tx_valid,
  output logic [TLP_W-1:0] tx_data,
  output logic             tx_last,
`ifdef DLSC_PCIE_S6_TX_ARBITER_STATS_EN
  input  logic             stat_clr,
  output logic [15:0]      stat_cpl_pkts,
  output logic [15:0]      stat_req_pkts,
  output logic [15:0]      stat_starve,
`endif
  output logic             gnt_cpl,
  output logic             gnt_req
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [5:0] BUF_THRESH = 6'(BUF_MIN);

  arb_state_e       state_q, state_d;
  logic [3:0]       starve_q, starve_d;
  logic             gnt_cpl_q, gnt_req_q;
  logic             load_en_s;
  logic             buf_ok_s;
  logic             grant_cpl_s, grant_req_s, forced_s;
  logic             cpl_ready_s, req_ready_s;
  logic             sel_valid_s, sel_last_s;
  logic [TLP_W-1:0] sel_data_s;

  assign buf_ok_s = (tx_buf_av >= BUF_THRESH);

  // Grant decision, only evaluated in IDLE; REQ wins a contended slot once
  // CPL has taken STARVE_LIMIT packets in a row while REQ waited.
  always_comb begin
    grant_cpl_s = 1'b0;
    grant_req_s = 1'b0;
    forced_s    = 1'b0;
    if ((state_q == ST_IDLE) && buf_ok_s) begin
      if (cpl_valid && req_valid) begin
        if (starve_q >= STARVE_MAX) begin
          grant_req_s = 1'b1;
          forced_s    = 1'b1;
        end else begin
          grant_cpl_s = 1'b1;
        end
      end else if (cpl_valid) begin
        grant_cpl_s = 1'b1;
      end else if (req_valid) begin
        grant_req_s = 1'b1;
      end else begin
        grant_cpl_s = 1'b0;
      end
    end else begin
      grant_cpl_s = 1'b0;
    end
  end

  // Next state: a grant is held until the granted source's last beat is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_cpl_s)      state_d = ST_CPL;
        else if (grant_req_s) state_d = ST_REQ;
        else                  state_d = ST_IDLE;
      end
      ST_CPL: begin
        if (cpl_valid && cpl_ready_s && cpl_last) state_d = ST_IDLE;
        else                                      state_d = ST_CPL;
      end
      ST_REQ: begin
        if (req_valid && req_ready_s && req_last) state_d = ST_IDLE;
        else                                      state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Starvation counter: counts CPL grants made over a waiting REQ.
  always_comb begin
    starve_d = starve_q;
    if (grant_req_s) begin
      starve_d = 4'd0;
    end else if (grant_cpl_s && req_valid && (starve_q < STARVE_MAX)) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  // State, starvation counter and grant status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      starve_q  <= 4'd0;
      gnt_cpl_q <= 1'b0;
      gnt_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      gnt_cpl_q <= (state_d == ST_CPL);
      gnt_req_q <= (state_d == ST_REQ);
    end
  end

  // Output decode: source ready and data mux follow the granted source.
  always_comb begin
    cpl_ready_s = 1'b0;
    req_ready_s = 1'b0;
    sel_valid_s = 1'b0;
    sel_data_s  = '0;
    sel_last_s  = 1'b0;
    case (state_q)
      ST_CPL: begin
        cpl_ready_s = load_en_s;
        sel_valid_s = cpl_valid;
        sel_data_s  = cpl_data;
        sel_last_s  = cpl_last;
      end
      ST_REQ: begin
        req_ready_s = load_en_s;
        sel_valid_s = req_valid;
        sel_data_s  = req_data;
        sel_last_s  = req_last;
      end
      default: begin
        cpl_ready_s = 1'b0;
        req_ready_s = 1'b0;
      end
    endcase
  end

  dlsc_pcie_s6_tx_arbiter_outreg #(
    .W (TLP_W)
  ) u_outreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_ready  (load_en_s),
    .in_valid  (sel_valid_s),
    .in_data   (sel_data_s),
    .in_last   (sel_last_s),
    .out_ready (tx_ready),
    .out_valid (tx_valid),
    .out_data  (tx_data),
    .out_last  (tx_last)
  );

  assign cpl_ready = cpl_ready_s;
  assign req_ready = req_ready_s;
  assign gnt_cpl   = gnt_cpl_q;
  assign gnt_req   = gnt_req_q;

`ifdef DLSC_PCIE_S6_TX_ARBITER_STATS_EN
  logic [15:0] stat_cpl_q, stat_cpl_d;
  logic [15:0] stat_req_q, stat_req_d;
  logic [15:0] stat_starve_q, stat_starve_d;

  // Statistics next values; a clear request overrides a same-cycle increment.
  always_comb begin
    stat_cpl_d    = stat_cpl_q;
    stat_req_d    = stat_req_q;
    stat_starve_d = stat_starve_q;
    if (stat_clr) begin
      stat_cpl_d    = 16'd0;
      stat_req_d    = 16'd0;
      stat_starve_d = 16'd0;
    end else begin
      stat_cpl_d    = grant_cpl_s ? sat_inc16(stat_cpl_q)    : stat_cpl_q;
      stat_req_d    = grant_req_s ? sat_inc16(stat_req_q)    : stat_req_q;
      stat_starve_d = forced_s    ? sat_inc16(stat_starve_q) : stat_starve_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cpl_q    <= 16'd0;
      stat_req_q    <= 16'd0;
      stat_starve_q <= 16'd0;
    end else begin
      stat_cpl_q    <= stat_cpl_d;
      stat_req_q    <= stat_req_d;
      stat_starve_q <= stat_starve_d;
    end
  end

  assign stat_cpl_pkts = stat_cpl_q;
  assign stat_req_pkts = stat_req_q;
  assign stat_starve   = stat_starve_q;
`endif

endmodule
